i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Byte-oriented I2C target (responder) for the tag FPGA. It lets an external I2C controller read and write a 256-entry register space inside the FPGA.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs bytes, and presents register writes and read requests on a simple single-cycle strobe interface toward a register file.
- Supports an 8-bit auto-incrementing register pointer.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit I2C address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk  in  1  system clock, must be at least 8x SCL frequency
- reset  in  1  asynchronous, active-high reset
- scl_in  in  1  SCL pad input (raw, asynchronous)
- sda_in  in  1  SDA pad input (raw, asynchronous)
- sda_out  out  1  SDA open-drain drive; 0 = pull low, 1 = release
- busy  out  1  high from addressed-START ACK until STOP or NAK exit
- wr_valid  out  1  one-clk strobe: register write
- wr_addr  out  8  register index for write, valid with wr_valid
- wr_data  out  8  write data, valid with wr_valid
- rd_req  out  1  one-clk strobe: register read requested
- rd_addr  out  8  register index for read, valid with rd_req
- rd_data  in  8  read data from register file

Behaviour:
- Reset (async, active-high), all outputs: sda_out=1, busy=0, wr_valid=0, rd_req=0, wr_addr=0, wr_data=0, rd_addr=0; pointer=0; state=IDLE.
- Input sampling:
  - scl_in/sda_in pass through SYNC_STAGES flops plus one history flop.
  - Edges are detected on synchronized values.
  - Synchronized inputs reset to 1.
- START: synced SDA 1->0 while synced SCL high. Valid in any state, including mid-byte; it restarts at ADDR and aborts any partial byte without a strobe.
- STOP: synced SDA 0->1 while synced SCL high. Returns to IDLE from any state, with sda_out=1 and busy=0.
- Bits are sampled on SCL rising edges, MSB first. Target-driven bits change one clk after a detected SCL falling edge.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits; bit0 is R/W (1 = read).
    - On the falling edge after bit 8: if addr==TARGET_ADDR, go to ADDR_ACK and drive sda_out=0.
    - Otherwise go to WAIT_STOP and leave sda_out=1.
  - ADDR_ACK: release sda_out on the next SCL falling edge and set busy=1.
    - Write: go to PTR.
    - Read: go to RDATA, loading the shift register from rd_data at this same falling edge.
  - PTR: shift 8 bits, load pointer, ACK (PTR_ACK), then go to WDATA. No strobe.
  - WDATA: shift 8 bits, then ACK (WDATA_ACK).
    - wr_valid pulses one clk after the falling edge after bit 8, with wr_addr=pointer and wr_data=byte.
    - Pointer then increments (8-bit wrap, 8'hFF->8'h00). Return to WDATA.
  - rd_req pulses with rd_addr=pointer one clk after the SCL rising edge of the ACK bit that precedes a read byte (address ACK or controller ACK).
    - rd_data must be stable from rd_req+2 clks.
    - rd_data is sampled at the following SCL falling edge.
  - RDATA: drive 8 bits from the shift register. Pointer increments when the byte is loaded.
  - RDATA_ACK: release SDA and sample the controller ACK on the SCL rising edge.
    - ACK (0): go to RDATA.
    - NAK (1): go to WAIT_STOP, with sda_out=1 and busy=0.
  - WAIT_STOP: ignore the bus until START or STOP.
- Repeated START retains the pointer. A write of only the pointer followed by repeated START + read reads from that pointer.
- wr_valid and rd_req are never asserted in the same clk. Each is a single-clk strobe per byte.
- A STOP or START arriving during an ACK bit releases sda_out within 1 clk of detection.
- No clock stretching. SCL is never driven.

Test Plan:
- Write: START, 0x84, 0x10, 0xAB, 0xCD, STOP -> four ACKs; wr_valid(0x10,0xAB) then (0x11,0xCD); busy falls on STOP; no rd_req.
- Combined read: START, 0x84, 0x20, repeated START, 0x85, controller ACK, NAK, STOP; register file returns 0x5A@0x20 and 0x6B@0x21 -> rd_req addresses 0x20 then 0x21; bytes 0x5A, 0x6B on SDA; no third rd_req.
- Wrong address: START, 0x86, 0x10, STOP -> sda_out stays 1 throughout; no strobes; busy stays 0.
- Pointer wrap: pointer 0xFF, write 0x01, 0x02 -> wr_addr 0xFF then 0x00.
- Abort mid-byte: after 0x84, 0x30, send 4 bits of data then STOP -> no wr_valid; state IDLE; sda_out=1. Next transaction works normally.
- Reset mid-ACK: assert reset while sda_out=0 in WDATA_ACK -> sda_out=1 and busy=0 immediately (async); pointer=0 after release.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: byte-oriented I2C target exposing a 256-entry register space.
// SCL/SDA are oversampled on clk. The block detects START, repeated START and STOP.
// It matches a fixed 7-bit address and ACKs each byte.
// Register writes and read requests are issued as single-cycle strobes.
//
// Ports:
//   clk      system clock (>= 8x SCL)
//   reset    asynchronous, active-high reset
//   scl_in   raw SCL pad input
//   sda_in   raw SDA pad input
//   sda_out  open-drain SDA drive (0 = pull low, 1 = release)
//   busy     addressed transaction in progress
//   wr_valid one-clk register write strobe, with wr_addr / wr_data
//   rd_req   one-clk register read request, with rd_addr
//   rd_data  read data from the register file, sampled at the next SCL fall
module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_t;

    // Input synchronizers plus one history flop for edge detection
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Bus events on synchronized values; START/STOP need SCL high in both samples
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    state_t              state,    state_nxt;
    logic [CNT_W-1:0]    bit_cnt,  bit_cnt_nxt;
    logic [BYTE_W-1:0]   shreg,    shreg_nxt;
    logic [BYTE_W-1:0]   ptr,      ptr_nxt;
    logic                rw,       rw_nxt;
    logic                sda_out_nxt;
    logic                busy_nxt;
    logic                wr_valid_nxt;
    logic [BYTE_W-1:0]   wr_addr_nxt;
    logic [BYTE_W-1:0]   wr_data_nxt;
    logic                rd_req_nxt;
    logic [BYTE_W-1:0]   rd_addr_nxt;
    logic                byte_done;
    logic                rx_state;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            sda_out  <= 1'b1;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            ptr      <= ptr_nxt;
            rw       <= rw_nxt;
            sda_out  <= sda_out_nxt;
            busy     <= busy_nxt;
            wr_valid <= wr_valid_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            rd_req   <= rd_req_nxt;
            rd_addr  <= rd_addr_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ptr_nxt      = ptr;
        rw_nxt       = rw;
        sda_out_nxt  = sda_out;
        busy_nxt     = busy;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        rd_req_nxt   = 1'b0;
        rd_addr_nxt  = rd_addr;

        byte_done = scl_fall && (bit_cnt == CNT_W'(8));
        rx_state  = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WDATA);

        if (stop_det) begin
            state_nxt   = ST_IDLE;
            sda_out_nxt = 1'b1;
            busy_nxt    = 1'b0;
        end else if (start_det) begin
            // Repeated START drops any partial byte but keeps the pointer
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = '0;
            sda_out_nxt = 1'b1;
        end else begin
            // Controller-driven bytes are shifted in MSB first on SCL rise
            if (rx_state && scl_rise && (bit_cnt < CNT_W'(8))) begin
                shreg_nxt   = {shreg[BYTE_W-2:0], sda_s};
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end

            case (state)
                ST_ADDR: begin
                    if (byte_done) begin
                        rw_nxt = shreg[0];
                        if (shreg[BYTE_W-1:1] == TARGET_ADDR) begin
                            state_nxt   = ST_ADDR_ACK;
                            sda_out_nxt = 1'b0;
                        end else begin
                            state_nxt = ST_WAIT_STOP;
                            busy_nxt  = 1'b0;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_rise && rw) begin
                        rd_req_nxt  = 1'b1;
                        rd_addr_nxt = ptr;
                    end
                    if (scl_fall) begin
                        busy_nxt    = 1'b1;
                        bit_cnt_nxt = '0;
                        if (rw) begin
                            state_nxt   = ST_RDATA;
                            shreg_nxt   = rd_data;
                            sda_out_nxt = rd_data[BYTE_W-1];
                            ptr_nxt     = ptr + BYTE_W'(1);
                        end else begin
                            state_nxt   = ST_PTR;
                            sda_out_nxt = 1'b1;
                        end
                    end
                end

                ST_PTR: begin
                    if (byte_done) begin
                        state_nxt   = ST_PTR_ACK;
                        sda_out_nxt = 1'b0;
                        ptr_nxt     = shreg;
                    end
                end

                ST_WDATA: begin
                    if (byte_done) begin
                        state_nxt    = ST_WDATA_ACK;
                        sda_out_nxt  = 1'b0;
                        wr_valid_nxt = 1'b1;
                        wr_addr_nxt  = ptr;
                        wr_data_nxt  = shreg;
                        ptr_nxt      = ptr + BYTE_W'(1);
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_nxt   = ST_WDATA;
                        sda_out_nxt = 1'b1;
                        bit_cnt_nxt = '0;
                    end
                end

                ST_RDATA: begin
                    // bit_cnt counts bits already clocked out to the controller
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                    if (scl_fall) begin
                        if (bit_cnt == CNT_W'(8)) begin
                            state_nxt   = ST_RDATA_ACK;
                            sda_out_nxt = 1'b1;
                        end else begin
                            sda_out_nxt = shreg[BYTE_W-2];
                            shreg_nxt   = {shreg[BYTE_W-2:0], 1'b0};
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            rd_req_nxt  = 1'b1;
                            rd_addr_nxt = ptr;
                        end else begin
                            state_nxt   = ST_WAIT_STOP;
                            sda_out_nxt = 1'b1;
                            busy_nxt    = 1'b0;
                        end
                    end
                    // Only reachable after an ACK: a NAK has already left this state
                    if (scl_fall) begin
                        state_nxt   = ST_RDATA;
                        bit_cnt_nxt = '0;
                        shreg_nxt   = rd_data;
                        sda_out_nxt = rd_data[BYTE_W-1];
                        ptr_nxt     = ptr + BYTE_W'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: directed I2C transactions with a
// strobe scoreboard (expected strobes queued at stimulus, observed strobes
// captured by a monitor and compared after each transaction).
module tb_i2c_target;

    localparam int Q = 50;   // quarter SCL period; 1 SCL period = 20 clk

    logic       clk;
    logic       reset;
    logic       scl;
    logic       sda_drv;
    logic       sda_line;
    logic       sda_out;
    logic       busy;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'h00;

    assign sda_line = sda_drv & sda_out;

    i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_out  (sda_out),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    logic [15:0] obs_wr [64];
    logic [7:0]  obs_rd [64];
    int obs_wr_n    = 0;
    int obs_rd_n    = 0;
    int sda_low_cnt = 0;
    int busy_cnt    = 0;
    int both_cnt    = 0;
    int wr_idx      = 0;
    int rd_idx      = 0;

    // Monitor: capture strobes and act as the register file
    always @(negedge clk) begin
        if (wr_valid && obs_wr_n < 64) begin
            obs_wr[obs_wr_n] = {wr_addr, wr_data};
            obs_wr_n = obs_wr_n + 1;
        end
        if (rd_req) begin
            if (obs_rd_n < 64) begin
                obs_rd[obs_rd_n] = rd_addr;
                obs_rd_n = obs_rd_n + 1;
            end
            rd_data = mem[rd_addr];
        end
        if (wr_valid && rd_req) both_cnt = both_cnt + 1;
        if (!sda_out)           sda_low_cnt = sda_low_cnt + 1;
        if (busy)               busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_strobes(input string tag);
        logic [15:0] e;
        logic [7:0]  r;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (wr_idx < obs_wr_n) begin
                check({tag, "_wr"}, obs_wr[wr_idx], e);
                wr_idx = wr_idx + 1;
            end else begin
                check({tag, "_wr_missing"}, 16'(obs_wr_n), 16'(wr_idx + 1));
            end
        end
        check({tag, "_wr_extra"}, 16'(obs_wr_n), 16'(wr_idx));
        while (exp_rd.size() > 0) begin
            r = exp_rd.pop_front();
            if (rd_idx < obs_rd_n) begin
                check({tag, "_rd"}, 16'(obs_rd[rd_idx]), 16'(r));
                rd_idx = rd_idx + 1;
            end else begin
                check({tag, "_rd_missing"}, 16'(obs_rd_n), 16'(rd_idx + 1));
            end
        end
        check({tag, "_rd_extra"}, 16'(obs_rd_n), 16'(rd_idx));
        check({tag, "_both"}, 16'(both_cnt), 16'(0));
    endtask

    task automatic bus_bit(input logic b, output logic sampled);
        sda_drv = b;
        #Q scl = 1'b1;
        #Q sampled = sda_line;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1;
        #Q scl = 1'b1;
        #Q sda_drv = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0;
        #Q scl = 1'b1;
        #Q sda_drv = 1'b1;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], dummy);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, b);
            d = {d[6:0], b};
        end
        bus_bit(ack_bit, b);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rbyte;
        logic       dummy;
        int         sda_snap;
        int         busy_snap;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
        reset   = 1'b1;
        scl     = 1'b1;
        sda_drv = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_out",  16'(sda_out),  16'(1));
        check("rst_busy",     16'(busy),     16'(0));
        check("rst_wr_valid", 16'(wr_valid), 16'(0));
        check("rst_rd_req",   16'(rd_req),   16'(0));
        check("rst_wr_addr",  16'(wr_addr),  16'(0));
        check("rst_wr_data",  16'(wr_data),  16'(0));
        check("rst_rd_addr",  16'(rd_addr),  16'(0));
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Write two registers from pointer 0x10
        bus_start();
        send_byte(8'h84, ack); check("wr_addr_ack", 16'(ack), 16'(0));
        check("wr_busy_hi", 16'(busy), 16'(1));
        send_byte(8'h10, ack); check("wr_ptr_ack", 16'(ack), 16'(0));
        exp_wr.push_back(16'h10AB);
        send_byte(8'hAB, ack); check("wr_d0_ack", 16'(ack), 16'(0));
        exp_wr.push_back(16'h11CD);
        send_byte(8'hCD, ack); check("wr_d1_ack", 16'(ack), 16'(0));
        bus_stop();
        check("wr_busy_lo", 16'(busy), 16'(0));
        compare_strobes("write");

        // Pointer write, repeated START, two-byte read
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'h6B;
        bus_start();
        send_byte(8'h84, ack); check("rd_waddr_ack", 16'(ack), 16'(0));
        send_byte(8'h20, ack); check("rd_ptr_ack", 16'(ack), 16'(0));
        bus_start();
        exp_rd.push_back(8'h20);
        send_byte(8'h85, ack); check("rd_raddr_ack", 16'(ack), 16'(0));
        exp_rd.push_back(8'h21);
        read_byte(1'b0, rbyte); check("rd_byte0", 16'(rbyte), 16'h005A);
        read_byte(1'b1, rbyte); check("rd_byte1", 16'(rbyte), 16'h006B);
        check("rd_busy_after_nak", 16'(busy), 16'(0));
        bus_stop();
        check("rd_sda_released", 16'(sda_out), 16'(1));
        compare_strobes("read");

        // Wrong address is ignored entirely
        sda_snap  = sda_low_cnt;
        busy_snap = busy_cnt;
        bus_start();
        send_byte(8'h86, ack); check("wa_addr_nak", 16'(ack), 16'(1));
        send_byte(8'h10, ack); check("wa_data_nak", 16'(ack), 16'(1));
        bus_stop();
        check("wa_sda_low", 16'(sda_low_cnt - sda_snap), 16'(0));
        check("wa_busy", 16'(busy_cnt - busy_snap), 16'(0));
        compare_strobes("wrongaddr");

        // Pointer wraps 0xFF -> 0x00
        bus_start();
        send_byte(8'h84, ack);
        send_byte(8'hFF, ack);
        exp_wr.push_back(16'hFF01);
        send_byte(8'h01, ack); check("wrap_d0_ack", 16'(ack), 16'(0));
        exp_wr.push_back(16'h0002);
        send_byte(8'h02, ack); check("wrap_d1_ack", 16'(ack), 16'(0));
        bus_stop();
        compare_strobes("wrap");

        // STOP after half a data byte: no strobe, bus released
        bus_start();
        send_byte(8'h84, ack);
        send_byte(8'h30, ack);
        bus_bit(1'b1, dummy);
        bus_bit(1'b0, dummy);
        bus_bit(1'b1, dummy);
        bus_bit(1'b0, dummy);
        bus_stop();
        check("abort_sda", 16'(sda_out), 16'(1));
        check("abort_busy", 16'(busy), 16'(0));
        compare_strobes("abort");
        bus_start();
        send_byte(8'h84, ack); check("post_abort_ack", 16'(ack), 16'(0));
        send_byte(8'h40, ack);
        exp_wr.push_back(16'h4077);
        send_byte(8'h77, ack); check("post_abort_d_ack", 16'(ack), 16'(0));
        bus_stop();
        compare_strobes("post_abort");

        // Reset while the target is holding the data ACK
        bus_start();
        send_byte(8'h84, ack);
        send_byte(8'h50, ack);
        exp_wr.push_back(16'h5099);
        for (int i = 7; i >= 0; i--) bus_bit(logic'((8'h99 >> i) & 8'h01), dummy);
        sda_drv = 1'b1;
        #1;
        check("mid_ack_sda", 16'(sda_out), 16'(0));
        check("mid_ack_busy", 16'(busy), 16'(1));
        reset = 1'b1;
        #1;
        check("async_rst_sda", 16'(sda_out), 16'(1));
        check("async_rst_busy", 16'(busy), 16'(0));
        scl = 1'b1;
        repeat (5) @(posedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        compare_strobes("reset_ack");

        // Pointer is zero after reset: a bare read starts at 0x00
        mem[8'h00] = 8'hC3;
        bus_start();
        exp_rd.push_back(8'h00);
        send_byte(8'h85, ack); check("post_rst_addr_ack", 16'(ack), 16'(0));
        read_byte(1'b1, rbyte); check("post_rst_byte", 16'(rbyte), 16'h00C3);
        bus_stop();
        compare_strobes("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
